// File: rtl/wt_store_wbuf.sv
// wt_store_wbuf: in-order write buffer with same-word merging, ID-tagged issue and ack-driven retire.
module wt_store_wbuf #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TID_W  = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_data_i,
    input  logic [DATA_W/8-1:0] req_be_i,
    output logic                mem_valid_o,
    input  logic                mem_ready_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_data_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [TID_W-1:0]    mem_tid_o,
    input  logic                ack_valid_i,
    input  logic [TID_W-1:0]    ack_tid_i,
    input  logic                flush_i,
    input  logic [ADDR_W-1:0]   ld_addr_i,
    output logic                ld_hit_o,
    output logic                empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int NS = 1 << TID_W;
    localparam int BW = DATA_W / 8;
    localparam logic [PW:0]       FULL  = (PW+1)'(DEPTH);
    localparam logic [TID_W:0]    NSL   = (TID_W+1)'(NS);
    localparam logic [ADDR_W-1:0] AMASK = ~ADDR_W'(3);

    typedef enum logic [1:0] {FREE, PEND, SENT, DONE} st_t;

    st_t               r_st   [DEPTH];
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [BW-1:0]     r_be   [DEPTH];
    logic [PW-1:0]     r_sidx [NS];
    logic [NS-1:0]     r_busy;
    logic [PW-1:0]     r_head, r_iss, r_tail;
    logic [PW:0]       r_cnt;
    logic [TID_W:0]    r_outs;

    logic [PW-1:0]     w_yng;
    logic [ADDR_W-1:0] w_req_addr;
    logic [TID_W-1:0]  w_tid;
    logic              w_fire, w_merge, w_alloc, w_ack, w_ret;

    assign w_yng       = r_tail - PW'(1);
    assign w_req_addr  = req_addr_i & AMASK;
    assign mem_valid_o = r_st[r_iss] == PEND && r_outs < NSL;
    assign mem_addr_o  = r_addr[r_iss];
    assign mem_data_o  = r_data[r_iss];
    assign mem_be_o    = r_be[r_iss];
    assign mem_tid_o   = w_tid;
    assign w_fire      = mem_valid_o && mem_ready_i;
    // The youngest entry may only absorb a store if it is not leaving on this same edge.
    assign w_merge     = req_valid_i && !flush_i && r_st[w_yng] == PEND &&
                         r_addr[w_yng] == w_req_addr && !(w_fire && r_iss == w_yng);
    assign req_ready_o = w_merge || r_cnt < FULL;
    assign w_alloc     = req_valid_i && !w_merge && r_cnt < FULL;
    assign w_ack       = ack_valid_i && r_busy[ack_tid_i];
    assign w_ret       = r_st[r_head] == DONE;
    assign empty_o     = r_cnt == '0;

    always_comb begin
        w_tid    = '0;
        ld_hit_o = 1'b0;
        for (int k = NS - 1; k >= 0; k--)
            w_tid = r_busy[k] ? w_tid : TID_W'(k);
        for (int k = 0; k < DEPTH; k++)
            ld_hit_o = ld_hit_o | (r_st[k] != FREE && r_addr[k] == (ld_addr_i & AMASK));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_st[k]   <= FREE;
                r_addr[k] <= '0;
                r_data[k] <= '0;
                r_be[k]   <= '0;
            end
            for (int k = 0; k < NS; k++)
                r_sidx[k] <= '0;
            r_busy <= '0;
            r_head <= '0;
            r_iss  <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
            r_outs <= '0;
        end else begin
            if (w_ack) begin
                r_busy[ack_tid_i]         <= 1'b0;
                r_st[r_sidx[ack_tid_i]]   <= DONE;
            end
            if (w_fire) begin
                r_busy[w_tid] <= 1'b1;
                r_sidx[w_tid] <= r_iss;
                r_st[r_iss]   <= SENT;
                r_iss         <= r_iss + PW'(1);
            end
            if (w_merge) begin
                for (int b = 0; b < BW; b++)
                    if (req_be_i[b])
                        r_data[w_yng][8*b +: 8] <= req_data_i[8*b +: 8];
                r_be[w_yng] <= r_be[w_yng] | req_be_i;
            end
            if (w_alloc) begin
                r_st[r_tail]   <= PEND;
                r_addr[r_tail] <= w_req_addr;
                r_data[r_tail] <= req_data_i;
                r_be[r_tail]   <= req_be_i;
                r_tail         <= r_tail + PW'(1);
            end
            if (w_ret) begin
                r_st[r_head] <= FREE;
                r_head       <= r_head + PW'(1);
            end
            r_cnt  <= r_cnt + (PW+1)'(w_alloc) - (PW+1)'(w_ret);
            r_outs <= r_outs + (TID_W+1)'(w_fire) - (TID_W+1)'(w_ack);
        end
    end
endmodule

// File: tb/tb_wt_store_wbuf.sv
// tb_wt_store_wbuf: directed scenarios plus random traffic, checked against a queue-of-stores model.
module tb_wt_store_wbuf;
    localparam int PEND = 0, SENT = 1, DONE = 2;

    logic        clk = 1'b0, rst_n;
    logic        req_valid, req_ready, mem_valid, mem_ready, ack_valid, flush, ld_hit, empty;
    logic [31:0] req_addr, req_data, mem_addr, mem_data, ld_addr;
    logic [3:0]  req_be, mem_be;
    logic [1:0]  mem_tid, ack_tid;

    typedef struct {
        int          id;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        int          st;
    } ent_t;

    ent_t q[$];
    bit   sbusy[4];
    int   sid[4];
    int   nid, n_chk, n_fail, n_iss;

    always #5 clk = ~clk;

    wt_store_wbuf dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_data_i(req_data), .req_be_i(req_be),
        .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
        .mem_data_o(mem_data), .mem_be_o(mem_be), .mem_tid_o(mem_tid),
        .ack_valid_i(ack_valid), .ack_tid_i(ack_tid), .flush_i(flush),
        .ld_addr_i(ld_addr), .ld_hit_o(ld_hit), .empty_o(empty)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int first_pend();
        foreach (q[i]) if (q[i].st == PEND) return i;
        return -1;
    endfunction

    function automatic int n_out();
        int n = 0;
        for (int k = 0; k < 4; k++) n += int'(sbusy[k]);
        return n;
    endfunction

    function automatic int low_free();
        for (int k = 0; k < 4; k++) if (!sbusy[k]) return k;
        return 0;
    endfunction

    // One clock: compare outputs mid-cycle against the model, then advance the model with this cycle's inputs.
    task automatic cycle();
        int   pi, tid, l;
        bit   ev, merge, hit, ret;
        ent_t e, y;
        @(negedge clk);
        pi    = first_pend();
        tid   = low_free();
        ev    = pi >= 0 && n_out() < 4;
        l     = q.size() - 1;
        merge = 0;
        if (l >= 0) begin
            y     = q[l];
            merge = req_valid && !flush && y.st == PEND && y.addr[31:2] == req_addr[31:2] &&
                    !(ev && mem_ready && pi == l);
        end
        hit = 0;
        foreach (q[i]) if (q[i].addr[31:2] == ld_addr[31:2]) hit = 1;
        chk("req_ready", req_ready, merge || q.size() < 8);
        chk("mem_valid", mem_valid, ev);
        chk("empty", empty, q.size() == 0);
        chk("ld_hit", ld_hit, hit);
        if (ev) begin
            e = q[pi];
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_data", mem_data, e.data);
            chk("mem_be", mem_be, e.be);
            chk("mem_tid", mem_tid, tid);
        end
        if (mem_valid && mem_ready) n_iss++;
        if (!rst_n) begin
            q.delete();
            for (int k = 0; k < 4; k++) sbusy[k] = 0;
        end else begin
            ret = q.size() > 0 && q[0].st == DONE;
            if (ack_valid && sbusy[ack_tid]) begin
                foreach (q[i]) if (q[i].id == sid[ack_tid]) begin
                    e = q[i]; e.st = DONE; q[i] = e;
                end
                sbusy[ack_tid] = 0;
            end
            if (ev && mem_ready) begin
                e = q[pi]; e.st = SENT; q[pi] = e;
                sbusy[tid] = 1;
                sid[tid]   = e.id;
            end
            if (merge) begin
                for (int b = 0; b < 4; b++) if (req_be[b]) y.data[8*b +: 8] = req_data[8*b +: 8];
                y.be = y.be | req_be;
                q[l] = y;
            end else if (req_valid && q.size() < 8) begin
                e.id = nid; e.addr = {req_addr[31:2], 2'b00}; e.data = req_data;
                e.be = req_be; e.st = PEND;
                nid++;
                q.push_back(e);
            end
            if (ret) q.delete(0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 0; ack_valid = 0; flush = 0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input bit fl);
        req_valid = 1; req_addr = a; req_data = d; req_be = be; flush = fl;
        cycle();
        req_valid = 0; flush = 0;
    endtask

    task automatic do_reset();
        idle();
        mem_ready = 0;
        rst_n = 0;
        cycle();
        rst_n = 1;
    endtask

    task automatic ack(input logic [1:0] t);
        ack_valid = 1; ack_tid = t;
        cycle();
        ack_valid = 0;
    endtask

    task automatic chk_reset();
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", mem_valid, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", mem_data, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_tid", mem_tid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_hit", ld_hit, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst_n = 0; mem_ready = 0; req_addr = 0; req_data = 0; req_be = 0; ack_tid = 0; ld_addr = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        chk_reset();

        // single store issues next cycle with tid 0; ack retires it and empty rises two cycles later
        mem_ready = 1;
        store(32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 0);
        #1;
        chk("t1_valid", mem_valid, 1);
        chk("t1_tid", mem_tid, 0);
        chk("t1_addr", mem_addr, 32'h8000_0004);
        chk("t1_data", mem_data, 32'hDEAD_BEEF);
        cycle();
        mem_ready = 0;
        ack(0);
        #1 chk("t1_empty_n1", empty, 0);
        cycle();
        #1 chk("t1_empty_n2", empty, 1);

        // merge of two halves into one word
        do_reset();
        store(32'h100, 32'h0000_1122, 4'h3, 0);
        store(32'h102, 32'h3344_0000, 4'hC, 0);
        #1;
        chk("mg_data", mem_data, 32'h3344_1122);
        chk("mg_be", mem_be, 4'hF);
        mem_ready = 1;
        cycle();
        mem_ready = 0;
        #1 chk("mg_single", mem_valid, 0);

        // flush disables merging: two entries
        do_reset();
        store(32'h100, 32'h0000_1122, 4'h3, 1);
        store(32'h102, 32'h3344_0000, 4'hC, 1);
        #1;
        chk("fl_data0", mem_data, 32'h0000_1122);
        chk("fl_be0", mem_be, 4'h3);
        mem_ready = 1;
        cycle();
        mem_ready = 0;
        #1;
        chk("fl_valid1", mem_valid, 1);
        chk("fl_addr1", mem_addr, 32'h100);
        chk("fl_data1", mem_data, 32'h3344_0000);
        chk("fl_be1", mem_be, 4'hC);

        // full buffer: distinct word stalls, youngest word still merges
        do_reset();
        for (int i = 0; i < 8; i++) store(32'h1000 + 4 * i, $urandom, 4'hF, 0);
        #1 chk("full_ready", req_ready, 0);
        req_valid = 1; req_addr = 32'h2000; req_data = 32'h5555_5555; req_be = 4'hF;
        #1 chk("full_stall", req_ready, 0);
        cycle();
        req_addr = 32'h101D; req_data = 32'hA5A5_A5A5; req_be = 4'h1;
        #1 chk("full_merge", req_ready, 1);
        cycle();
        req_valid = 0;

        // outstanding limit: four issues, then a freed tid is reused
        do_reset();
        mem_ready = 1;
        n_iss = 0;
        for (int i = 0; i < 6; i++) store(32'h4000 + 4 * i, $urandom, 4'hF, 0);
        repeat (4) cycle();
        #1;
        chk("ol_issued", n_iss, 4);
        chk("ol_valid", mem_valid, 0);
        ack(2);
        #1;
        chk("ol_valid2", mem_valid, 1);
        chk("ol_tid2", mem_tid, 2);
        cycle();

        // out-of-order acks: retire waits for the head, then one per cycle
        do_reset();
        mem_ready = 1;
        n_iss = 0;
        for (int i = 0; i < 3; i++) store(32'h5000 + 4 * i, $urandom, 4'hF, 0);
        cycle();
        mem_ready = 0;
        chk("ooo_issued", n_iss, 3);
        ld_addr = 32'h5000;
        ack(2);
        ack(1);
        cycle();
        #1;
        chk("ooo_hold_hit", ld_hit, 1);
        chk("ooo_hold_empty", empty, 0);
        ack(0);
        #1 chk("ooo_n1_hit0", ld_hit, 1);
        cycle();
        #1 chk("ooo_n2_hit0", ld_hit, 0);
        ld_addr = 32'h5004;
        #1 chk("ooo_n2_hit1", ld_hit, 1);
        cycle();
        #1;
        chk("ooo_n3_hit1", ld_hit, 0);
        chk("ooo_n3_empty", empty, 0);
        cycle();
        #1 chk("ooo_n4_empty", empty, 1);

        // load hazard, then reset mid-flight and a stale ack
        do_reset();
        store(32'h200, 32'h1, 4'hF, 0);
        store(32'h300, 32'h2, 4'hF, 0);
        ld_addr = 32'h203;
        #1 chk("hz_hit", ld_hit, 1);
        ld_addr = 32'h204;
        #1 chk("hz_miss", ld_hit, 0);
        mem_ready = 1;
        repeat (2) cycle();
        mem_ready = 0;
        rst_n = 0;
        cycle();
        rst_n = 1;
        ld_addr = 32'h200;
        chk_reset();
        ack(0);
        mem_ready = 1;
        store(32'h600, 32'h6, 4'hF, 0);
        #1;
        chk("hz_post_valid", mem_valid, 1);
        chk("hz_post_tid", mem_tid, 0);
        cycle();
        mem_ready = 0;
        repeat (3) cycle();
        #1 chk("hz_post_empty", empty, 0);

        // random traffic against the model
        do_reset();
        repeat (3000) begin
            int bl[$];
            req_valid = 1'($urandom % 2);
            req_addr  = 32'h9000 + ($urandom % 6) * 4 + $urandom % 4;
            req_data  = $urandom;
            req_be    = 4'($urandom_range(1, 15));
            flush     = ($urandom % 5) == 0;
            mem_ready = ($urandom % 3) != 0;
            ld_addr   = 32'h9000 + ($urandom % 8) * 4 + $urandom % 4;
            rst_n     = ($urandom % 500) != 0;
            for (int k = 0; k < 4; k++) if (sbusy[k]) bl.push_back(k);
            ack_valid = bl.size() > 0 && ($urandom % 3) == 0;
            ack_tid   = bl.size() > 0 ? 2'(bl[$urandom % bl.size()]) : 2'd0;
            cycle();
        end
        rst_n = 1;
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
